// File: rtl/result_serializer_pkg.sv
// Shared definitions for the FP datapath serial framing blocks.
package result_serializer_pkg;

  // Word length shared by the operand deserializer, the adder and this serializer.
  localparam int unsigned FP_WORD_WIDTH = 32;

  // Serializer state encoding.
  localparam int unsigned STATE_WIDTH = 2;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/result_serializer.sv
// Parallel-to-serial output stage: captures a result word on load_in and
// shifts it out one bit per accepted transfer, with downstream backpressure.
module result_serializer
  import result_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = FP_WORD_WIDTH,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             load_in,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             shift_en_in,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy_out,
  output logic             done_out
);

  localparam int unsigned          CNT_WIDTH  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     shadow_q, shadow_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 serial_out_d;
  logic                 serial_valid_d;
  logic                 busy_d;
  logic                 done_d;

  // Move the word one place toward the output end, zero filling behind it.
  function automatic logic [WIDTH-1:0] shift_toward_out(input logic [WIDTH-1:0] w);
    if (LSB_FIRST) begin
      return {1'b0, w[WIDTH-1:1]};
    end else begin
      return {w[WIDTH-2:0], 1'b0};
    end
  endfunction

  // Bit currently sitting at the output end of the shadow register.
  function automatic logic out_bit(input logic [WIDTH-1:0] w);
    if (LSB_FIRST) begin
      return w[0];
    end else begin
      return w[WIDTH-1];
    end
  endfunction

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    count_d  = count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (load_in) begin
          shadow_d = parallel_in;
          count_d  = '0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (shift_en_in) begin
          shadow_d = shift_toward_out(shadow_q);
          if (count_q == LAST_COUNT) begin
            // Last accept: park the counter at zero instead of wrapping.
            count_d = '0;
            state_d = ST_DONE;
          end else begin
            count_d = count_q + CNT_WIDTH'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        shadow_d = '0;
        count_d  = '0;
      end
    endcase

    // Outputs are registered, so decode them from the upcoming state.
    serial_valid_d = (state_d == ST_SHIFT);
    serial_out_d   = serial_valid_d & out_bit(shadow_d);
    busy_d         = (state_d == ST_SHIFT) || (state_d == ST_DONE);
    done_d         = (state_d == ST_DONE);
  end

  // State, datapath and output registers; reset aborts any word in flight.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      shadow_q     <= '0;
      count_q      <= '0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      busy_out     <= 1'b0;
      done_out     <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      count_q      <= count_d;
      serial_out   <= serial_out_d;
      serial_valid <= serial_valid_d;
      busy_out     <= busy_d;
      done_out     <= done_d;
    end
  end

endmodule
